// File: rtl/shift_operand_decode.sv
// rtl/shift_operand_decode.sv - decode/issue stage producing registered shifter/extender controls
//
// Takes an ARM-style instruction and reads Rm (and Rs for register-shifted-register
// forms) from a single-port register file. It registers shifter_in, shift_value,
// t and E for the shifter/extender downstream.
// A register-shifted-register form needs one extra cycle on the shared read port.
// That cycle is the RS_READ state.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake, instr is the instruction word
//   rf_addr/rf_data        register-file read port (combinational read)
//   stall, flush           downstream hold, kill of in-flight/registered operation
//   out_valid, shifter_in, shift_value, t, E, illegal   registered controls
//
// Optional feature macro: SHIFT_OPERAND_HALFWORD_EN. It decodes halfword/signed
// immediate-offset transfers. Without it, that encoding is illegal.

module shift_operand_decode #(
   parameter int RF_AW     = 4,
   parameter int SAT_LIMIT = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   output logic [RF_AW-1:0]  rf_addr,
   input  logic [31:0]       rf_data,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   output logic [31:0]       shifter_in,
   output logic [5:0]        shift_value,
   output logic [2:0]        t,
   output logic              E,
   output logic              illegal
);

   typedef enum logic {IDLE, RS_READ} state_t;

   localparam logic [7:0] SAT8 = 8'(SAT_LIMIT);
   localparam logic [5:0] SAT6 = 6'(SAT_LIMIT);

   state_t      state;
   logic [31:0] held_rm;
   logic [3:0]  held_rs;
   logic [1:0]  held_t;

   logic [31:0] dec_sin;
   logic [5:0]  dec_sv;
   logic [2:0]  dec_t;
   logic        dec_e;
   logic        dec_ill;
   logic        dec_rsr;
   logic [5:0]  rs_sv;

   // The condition field plays no part in operand decode.
   logic unused_cond;
   assign unused_cond = ^instr[31:28];

   assign in_ready = (state == IDLE) && !stall && !flush;

   // Rs comes from the captured instruction.
   // Upstream may present a new word while RS_READ is in progress.
   assign rf_addr = (state == RS_READ) ? RF_AW'(held_rs) : RF_AW'(instr[3:0]);

   // Single-cycle decode from the instruction presented in IDLE.
   always_comb begin
      dec_sin = 32'd0;
      dec_sv  = 6'd0;
      dec_t   = 3'd0;
      dec_e   = 1'b0;
      dec_ill = 1'b0;
      dec_rsr = 1'b0;
      case (instr[27:25])
         3'b001: begin
            dec_sin = {24'd0, instr[7:0]};
            dec_sv  = {2'b00, instr[11:8]};
            dec_t   = 3'd4;
         end
         3'b000: begin
            if (!instr[4]) begin
               dec_sin = rf_data;
               dec_t   = {1'b0, instr[6:5]};
               dec_sv  = {1'b0, instr[11:7]};
               // An encoded 0 means 32 for LSR/ASR. ROR #0 (RRX) stays 0.
               if ((instr[11:7] == 5'd0) && ((instr[6:5] == 2'b01) || (instr[6:5] == 2'b10)))
                  dec_sv = 6'd32;
            end else if (!instr[7]) begin
               dec_rsr = 1'b1;
            end
`ifdef SHIFT_OPERAND_HALFWORD_EN
            else if (instr[22]) begin
               dec_sin = {24'd0, instr[11:8], instr[3:0]};
               dec_t   = 3'd1;
               dec_e   = 1'b1;
            end
`endif
            else begin
               dec_ill = 1'b1;
            end
         end
         3'b010: begin
            dec_sin = {20'd0, instr[11:0]};
            dec_t   = 3'd5;
            dec_e   = 1'b1;
         end
         3'b101: begin
            dec_sin = {8'd0, instr[23:0]};
            dec_t   = 3'd4;
            dec_e   = 1'b1;
         end
         default: dec_ill = 1'b1;
      endcase
   end

   // Shift amount for register-specified shifts, taken from Rs read in RS_READ.
   always_comb begin
      rs_sv = SAT6;
      if (held_t == 2'b11)
         rs_sv = {1'b0, rf_data[4:0]};
      else if (rf_data[7:0] < SAT8)
         rs_sv = rf_data[5:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         out_valid   <= 1'b0;
         shifter_in  <= 32'd0;
         shift_value <= 6'd0;
         t           <= 3'd0;
         E           <= 1'b0;
         illegal     <= 1'b0;
         held_rm     <= 32'd0;
         held_rs     <= 4'd0;
         held_t      <= 2'd0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         illegal   <= 1'b0;
      end else if (!stall) begin
         case (state)
            IDLE: begin
               if (in_valid && dec_rsr) begin
                  held_rm   <= rf_data;
                  held_rs   <= instr[11:8];
                  held_t    <= instr[6:5];
                  state     <= RS_READ;
                  out_valid <= 1'b0;
                  illegal   <= 1'b0;
               end else if (in_valid) begin
                  out_valid   <= 1'b1;
                  shifter_in  <= dec_sin;
                  shift_value <= dec_sv;
                  t           <= dec_t;
                  E           <= dec_e;
                  illegal     <= dec_ill;
               end else begin
                  out_valid <= 1'b0;
                  illegal   <= 1'b0;
               end
            end
            RS_READ: begin
               out_valid   <= 1'b1;
               shifter_in  <= held_rm;
               shift_value <= rs_sv;
               t           <= {1'b0, held_t};
               E           <= 1'b0;
               illegal     <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_operand_decode.sv
// tb/tb_shift_operand_decode.sv - directed self-checking bench for shift_operand_decode

module tb_shift_operand_decode;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = 32'd0;
   logic [3:0]  rf_addr;
   logic [31:0] rf_data;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic [31:0] shifter_in;
   logic [5:0]  shift_value;
   logic [2:0]  t;
   logic        E;
   logic        illegal;

   logic [31:0] regs [16];
   int total = 0;
   int bad = 0;

   // {out_valid, shifter_in, shift_value, t, E, illegal}
   logic [43:0] obs;
   assign obs = {out_valid, shifter_in, shift_value, t, E, illegal};

   assign rf_data = regs[rf_addr];

   always #5 clk = ~clk;

   shift_operand_decode #(.RF_AW(4), .SAT_LIMIT(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rf_addr(rf_addr), .rf_data(rf_data), .stall(stall),
      .flush(flush), .out_valid(out_valid), .shifter_in(shifter_in),
      .shift_value(shift_value), .t(t), .E(E), .illegal(illegal)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step;
      step;
      reset = 1'b0;
      total++;
      if ({obs, in_ready} !== {44'd0, 1'b1}) begin
         bad++;
         $display("FAIL reset got=%h ready=%b exp=0 ready=1", obs, in_ready);
      end
   endtask

   task automatic test_dp_imm;
      instr = 32'hE3A0_14FF;
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      total++;
      if (obs !== {1'b1, 32'h0000_00FF, 6'd4, 3'd4, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL dp_imm got=%h", obs);
      end
      step;
      total++;
      if (obs !== {1'b0, 32'h0000_00FF, 6'd4, 3'd4, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL idle_hold got=%h", obs);
      end
   endtask

   task automatic test_shift_imm;
      regs[2] = 32'h8000_0000;
      instr = 32'hE1A0_0022;
      in_valid = 1'b1;
      #1;
      total++;
      if ({in_ready, rf_addr} !== {1'b1, 4'd2}) begin
         bad++;
         $display("FAIL rm_addr got ready=%b addr=%h exp ready=1 addr=2", in_ready, rf_addr);
      end
      step;
      total++;
      if (obs !== {1'b1, 32'h8000_0000, 6'd32, 3'd1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL lsr0 got=%h", obs);
      end
      instr = 32'hE1A0_0062;
      step;
      total++;
      if (obs !== {1'b1, 32'h8000_0000, 6'd0, 3'd3, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL ror0 got=%h", obs);
      end
      instr = 32'hE1A0_0282;
      step;
      in_valid = 1'b0;
      total++;
      if (obs !== {1'b1, 32'h8000_0000, 6'd5, 3'd0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL lsl5 got=%h", obs);
      end
      step;
   endtask

   task automatic rsr_case(input logic [31:0] ins, input logic [31:0] rs,
                           input logic [5:0] exp_sv, input logic [2:0] exp_t);
      regs[1] = 32'hF000_0000;
      regs[3] = rs;
      instr = ins;
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      regs[1] = 32'h0;
      total++;
      if ({in_ready, rf_addr, out_valid} !== {1'b0, 4'd3, 1'b0}) begin
         bad++;
         $display("FAIL rs_read ins=%h got ready=%b addr=%h valid=%b exp 0/3/0",
                  ins, in_ready, rf_addr, out_valid);
      end
      step;
      total++;
      if ({obs, in_ready} !== {1'b1, 32'hF000_0000, exp_sv, exp_t, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL rsr ins=%h rs=%h got=%h ready=%b exp sv=%0d t=%0d",
                  ins, rs, obs, in_ready, exp_sv, exp_t);
      end
      step;
   endtask

   task automatic test_rsr;
      rsr_case(32'hE1A0_0351, 32'h0000_0045, 6'd32, 3'd2);
      rsr_case(32'hE1A0_0371, 32'h0000_0045, 6'd5,  3'd3);
      rsr_case(32'hE1A0_0311, 32'h0000_001F, 6'd31, 3'd0);
      rsr_case(32'hE1A0_0331, 32'h0000_0020, 6'd32, 3'd1);
      rsr_case(32'hE1A0_0311, 32'h0000_0100, 6'd0,  3'd0);
   endtask

   task automatic test_rsr_stall;
      regs[1] = 32'hF000_0000;
      regs[3] = 32'h0000_0045;
      instr = 32'hE1A0_0351;
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         total++;
         if ({out_valid, in_ready} !== 2'b00) begin
            bad++;
            $display("FAIL rsr_stall cyc=%0d got valid=%b ready=%b exp 0/0", i, out_valid, in_ready);
         end
      end
      stall = 1'b0;
      step;
      total++;
      if (obs !== {1'b1, 32'hF000_0000, 6'd32, 3'd2, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL rsr_stall_out got=%h", obs);
      end
      step;
   endtask

   task automatic test_back_to_back;
      instr = 32'hEA80_0010;
      in_valid = 1'b1;
      step;
      total++;
      if (obs !== {1'b1, 32'h0080_0010, 6'd0, 3'd4, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL branch got=%h", obs);
      end
      stall = 1'b1;
      instr = 32'hE59F_0FFF;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL stall_ready got=%b exp=0", in_ready);
      end
      step;
      total++;
      if (obs !== {1'b1, 32'h0080_0010, 6'd0, 3'd4, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL stall_hold got=%h", obs);
      end
      stall = 1'b0;
      step;
      in_valid = 1'b0;
      total++;
      if (obs !== {1'b1, 32'h0000_0FFF, 6'd0, 3'd5, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL load got=%h", obs);
      end
      step;
   endtask

   task automatic test_illegal;
      instr = 32'hE700_0000;
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      total++;
      if (obs !== {1'b1, 32'h0, 6'd0, 3'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL illegal got=%h", obs);
      end
      step;
      total++;
      if ({out_valid, illegal} !== 2'b00) begin
         bad++;
         $display("FAIL illegal_clear got valid=%b ill=%b exp 0/0", out_valid, illegal);
      end
   endtask

   task automatic test_flush;
      regs[1] = 32'hF000_0000;
      regs[3] = 32'h0000_0045;
      instr = 32'hE1A0_0351;
      in_valid = 1'b1;
      step;
      flush = 1'b1;
      instr = 32'hE3A0_14FF;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL flush_ready got=%b exp=0", in_ready);
      end
      step;
      flush = 1'b0;
      #1;
      total++;
      if ({out_valid, illegal, in_ready, rf_addr} !== {3'b001, 4'hF}) begin
         bad++;
         $display("FAIL flush_idle got valid=%b ill=%b ready=%b addr=%h exp 0/0/1/f",
                  out_valid, illegal, in_ready, rf_addr);
      end
      step;
      in_valid = 1'b0;
      total++;
      if (obs !== {1'b1, 32'h0000_00FF, 6'd4, 3'd4, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL flush_next got=%h", obs);
      end
      instr = 32'hE700_0000;
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      stall = 1'b1;
      flush = 1'b1;
      step;
      stall = 1'b0;
      flush = 1'b0;
      total++;
      if ({out_valid, illegal} !== 2'b00) begin
         bad++;
         $display("FAIL flush_over_stall got valid=%b ill=%b exp 0/0", out_valid, illegal);
      end
   endtask

   task automatic test_halfword;
      instr = 32'hE1C0_0AB5;
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      total++;
`ifdef SHIFT_OPERAND_HALFWORD_EN
      if (obs !== {1'b1, 32'h0000_00A5, 6'd0, 3'd1, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL halfword got=%h", obs);
      end
`else
      if (obs !== {1'b1, 32'h0, 6'd0, 3'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL halfword_illegal got=%h", obs);
      end
`endif
      step;
   endtask

   task automatic test_reset_mid;
      regs[1] = 32'h1234_5678;
      regs[3] = 32'h0000_0004;
      instr = 32'hE1A0_0351;
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      stall = 1'b1;
      flush = 1'b1;
      reset = 1'b1;
      step;
      reset = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      #1;
      total++;
      if ({obs, in_ready} !== {44'd0, 1'b1}) begin
         bad++;
         $display("FAIL reset_mid got=%h ready=%b exp=0 ready=1", obs, in_ready);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 32'h0;
      regs[15] = 32'hDEAD_BEEF;
      test_reset;
      test_dp_imm;
      test_shift_imm;
      test_rsr;
      test_rsr_stall;
      test_back_to_back;
      test_illegal;
      test_flush;
      test_halfword;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
